direction_input_ctrl: RTL and testbench
=======================================

// Module: direction_input_ctrl
// PURPOSE
//  Front end that produces the directions/enMove pair consumed by the cursor movement logic.
//  Turns four raw active-low push buttons into clean one-cycle move requests.
//  Per-button path: synchronise, then debounce.
//  Rate control: one step on press, then auto-repeat after a hold delay.
//  Sits between the board KEY pins and the paint cursor position register.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000    consecutive stable cycles before a button level is accepted (10 ms @ 50 MHz)
//  FIRST_DELAY      25000000  cycles from first step to first auto-repeat step (0.5 s)
//  REPEAT_PERIOD    5000000   cycles between auto-repeat steps (0.1 s)
//  Counter widths are $clog2 of the largest value; every parameter is >= 2.
// PORTS
//  clock       in   1  system clock; all state on rising edge
//  resetn      in   1  asynchronous, active-low reset
//  btn_n       in   4  raw buttons, active-low, asynchronous; [3]=left [2]=up [1]=right [0]=down
//  directions  out  4  registered step direction, same bit order as btn_n, active-high
//  enMove      out  1  registered one-cycle step strobe; directions is valid whenever enMove=1
// BEHAVIOUR
//  Reset values:
//   - directions=0, enMove=0, FSM=IDLE, all counters=0.
//   - Sync and debounce flops read "released" (1).
//  Sync: 2-flop synchroniser per bit. Nothing downstream uses unsynchronised btn_n.
//  Debounce, per bit:
//   - A counter restarts whenever the synced level differs from the accepted level.
//   - The new level is accepted on the cycle the counter reaches DEBOUNCE_CYCLES-1.
//   - Pulses shorter than DEBOUNCE_CYCLES cycles are never accepted.
//  Combine: pressed = ~accepted.
//   - Left+right both pressed: both horizontal bits are forced to 0.
//   - Up+down both pressed: both vertical bits are forced to 0.
//   - Result is called dir_now. dir_now=0 means no request.
//  FSM (timer resets to 0 on every state entry and on every emitted step):
//   - IDLE: dir_now!=0 -> emit step, go to FIRST.
//   - FIRST:
//       dir_now=0 -> IDLE, no step.
//       dir_now changed to another nonzero value -> emit step, stay in FIRST.
//       timer==FIRST_DELAY-1 -> emit step, go to REPEAT.
//   - REPEAT:
//       dir_now=0 -> IDLE.
//       dir_now changed -> emit step, go to FIRST.
//       timer==REPEAT_PERIOD-1 -> emit step.
//   - Priority within a cycle: release > change > timer expiry.
//  Emitting a step: on the next edge, enMove=1 for exactly one cycle and directions=dir_now.
//  directions holds its value between steps and clears to 0 on the edge that enters IDLE.
//  Latency: first enMove is high DEBOUNCE_CYCLES+3 edges after the edge that first samples the press.
//   - 2 edges for sync, DEBOUNCE_CYCLES for stability, 1 for the output register.
//  enMove is never high on two consecutive cycles.
//  Reset asserted mid-operation:
//   - Outputs clear immediately and asynchronously.
//   - A button still held at reset release must re-debounce fully before any step.
// STRUCTURE
//  Shared package (paint_pkg):
//   - DIR_LEFT=3, DIR_UP=2, DIR_RIGHT=1, DIR_DOWN=0.
//   - FSM state encoding: IDLE, FIRST, REPEAT.
//  Sub-module button_debounce (sync + debounce for one bit, DEBOUNCE_CYCLES param), instanced 4x.
//  The top level holds the combine logic, FSM and timer.
// TESTING
//  Bench parameters: DEBOUNCE_CYCLES=4, FIRST_DELAY=10, REPEAT_PERIOD=3.
//  1. Hold left, btn_n=4'b0111, 40 cycles -> enMove at edge 7 with dirs=1000; next at 17; then 20, 23, 26, ...
//  2. Bounce: btn_n[2] low for 3 cycles, high 2, low 3 -> no enMove, directions stays 0.
//  3. btn_n=4'b0101 (left+right) held -> no enMove. Then add up (4'b0001) -> one step with dirs=0100.
//  4. In REPEAT with left, switch to left+up (4'b0011) -> step with 1100 after debounce; next step 10 cycles later.
//  5. Release all in REPEAT -> IDLE after debounce, directions=0, no further enMove.
//  6. Assert resetn=0 between edges while in REPEAT -> outputs 0 at once; keep left held through release -> first enMove 7 edges after release.

Source files
------------

// File: rtl/paint_pkg.sv
// Shared definitions for the paint cursor front end: direction bit positions,
// step FSM encoding and the opposing-button cancellation helper.
package paint_pkg;

  localparam int DIR_LEFT  = 3;
  localparam int DIR_UP    = 2;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_DOWN  = 0;
  localparam int NUM_BTN   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_REPEAT = 2'd2
  } step_state_e;

  // Opposing directions cancel each other on their own axis only.
  function automatic logic [NUM_BTN-1:0] combine_dirs(input logic [NUM_BTN-1:0] pressed);
    logic [NUM_BTN-1:0] d;
    d = pressed;
    if (pressed[DIR_LEFT] && pressed[DIR_RIGHT]) begin
      d[DIR_LEFT]  = 1'b0;
      d[DIR_RIGHT] = 1'b0;
    end
    if (pressed[DIR_UP] && pressed[DIR_DOWN]) begin
      d[DIR_UP]   = 1'b0;
      d[DIR_DOWN] = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: 2-flop synchroniser followed by a stability counter that only
// accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw_n_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced level disagrees with the accepted one.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/direction_input_ctrl.sv
// Turns four raw active-low buttons into registered one-cycle move strobes
// with a step on press and auto-repeat after a hold delay.
module direction_input_ctrl
  import paint_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIRST_DELAY     = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] directions,
  output logic               enMove
);

  localparam int TMAX = (FIRST_DELAY > REPEAT_PERIOD) ? FIRST_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] FIRST_LAST  = TW'(FIRST_DELAY - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_PERIOD - 1);

  logic [NUM_BTN-1:0] accepted;
  logic [NUM_BTN-1:0] dir_now;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock  (clock),
      .resetn (resetn),
      .raw_n_i(btn_n[i]),
      .level_o(accepted[i])
    );
  end

  assign dir_now = combine_dirs(~accepted);

  step_state_e        state_q;
  logic [TW-1:0]      timer_q;
  logic [NUM_BTN-1:0] dir_q;
  logic               en_q;
  logic               changed;

  // dir_q always holds the last emitted direction, so it doubles as the change reference.
  assign changed = (dir_now != dir_q);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      dir_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (dir_now != '0) begin
            en_q    <= 1'b1;
            dir_q   <= dir_now;
            state_q <= ST_FIRST;
          end
        end
        ST_FIRST, ST_REPEAT: begin
          if (dir_now == '0) begin
            state_q <= ST_IDLE;
            dir_q   <= '0;
            timer_q <= '0;
          end else if (changed && !en_q) begin
            // A change landing right after a step waits one cycle so strobes never abut.
            en_q    <= 1'b1;
            dir_q   <= dir_now;
            timer_q <= '0;
            state_q <= ST_FIRST;
          end else if (!changed &&
                       (((state_q == ST_FIRST)  && (timer_q == FIRST_LAST)) ||
                        ((state_q == ST_REPEAT) && (timer_q == REPEAT_LAST)))) begin
            en_q    <= 1'b1;
            timer_q <= '0;
            state_q <= ST_REPEAT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          timer_q <= '0;
          dir_q   <= '0;
        end
      endcase
    end
  end

  assign directions = dir_q;
  assign enMove     = en_q;

endmodule

// File: tb/tb_direction_input_ctrl.sv
// Directed bench for direction_input_ctrl with short debounce/repeat timing;
// every step edge below is counted from the edge that first samples the new btn_n.
module tb_direction_input_ctrl;

  logic       clock;
  logic       resetn;
  logic [3:0] btn_n;
  logic [3:0] directions;
  logic       enMove;

  int checks = 0;
  int errors = 0;

  direction_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .FIRST_DELAY    (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .btn_n     (btn_n),
    .directions(directions),
    .enMove    (enMove)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Advance n edges; enMove must be high exactly on the edges flagged in mask
  // (bit k = k-th edge of this window), with directions == d on those edges.
  task automatic win(input string tag, input int n, input logic [63:0] mask, input logic [3:0] d);
    for (int k = 1; k <= n; k++) begin
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("%s en@%0d", tag, k), {3'b000, enMove}, {3'b000, mask[k]});
      if (mask[k]) chk($sformatf("%s dir@%0d", tag, k), directions, d);
    end
  endtask

  initial begin
    resetn = 1'b0;
    btn_n  = 4'b1111;
    #2;
    chk("reset_dir", directions, 4'b0000);
    chk("reset_en", {3'b000, enMove}, 4'b0000);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;

    // Hold left: steps at 7, 17, then every 3 cycles.
    btn_n = 4'b0111;
    win("hold_left", 40,
        (64'd1 << 7) | (64'd1 << 17) | (64'd1 << 20) | (64'd1 << 23) | (64'd1 << 26) |
        (64'd1 << 29) | (64'd1 << 32) | (64'd1 << 35) | (64'd1 << 38), 4'b1000);
    chk("hold_left_dir", directions, 4'b1000);

    // Release in REPEAT: two more repeats while the release debounces, then IDLE.
    btn_n = 4'b1111;
    win("rel_repeat", 6, (64'd1 << 1) | (64'd1 << 4), 4'b1000);
    chk("rel_before_idle", directions, 4'b1000);
    win("rel_idle", 1, 64'd0, 4'b0000);
    chk("rel_dir_cleared", directions, 4'b0000);
    win("rel_quiet", 8, 64'd0, 4'b0000);

    // Bounce on up: 3 low, 2 high, 3 low never reaches 4 stable cycles.
    btn_n = 4'b1011;
    win("bounce_a", 3, 64'd0, 4'b0000);
    btn_n = 4'b1111;
    win("bounce_b", 2, 64'd0, 4'b0000);
    btn_n = 4'b1011;
    win("bounce_c", 3, 64'd0, 4'b0000);
    btn_n = 4'b1111;
    win("bounce_d", 10, 64'd0, 4'b0000);
    chk("bounce_dir", directions, 4'b0000);

    // Left+right cancel; adding up yields a pure up step.
    btn_n = 4'b0101;
    win("lr_cancel", 12, 64'd0, 4'b0000);
    chk("lr_cancel_dir", directions, 4'b0000);
    btn_n = 4'b0001;
    win("lr_plus_up", 7, 64'd1 << 7, 4'b0100);
    btn_n = 4'b1111;
    win("lr_release", 10, 64'd0, 4'b0000);
    chk("lr_release_dir", directions, 4'b0000);

    // Left into REPEAT, then left+up: change step at r7, next step FIRST_DELAY later.
    btn_n = 4'b0111;
    win("chg_left", 21, (64'd1 << 7) | (64'd1 << 17) | (64'd1 << 20), 4'b1000);
    btn_n = 4'b0011;
    win("chg_repeat", 5, (64'd1 << 2) | (64'd1 << 5), 4'b1000);
    win("chg_step", 12, (64'd1 << 2) | (64'd1 << 12), 4'b1100);

    // Async reset between edges while a strobe is high.
    #1;
    resetn = 1'b0;
    btn_n  = 4'b0111;
    #1;
    chk("async_rst_dir", directions, 4'b0000);
    chk("async_rst_en", {3'b000, enMove}, 4'b0000);
    @(negedge clock);
    chk("rst_hold_dir", directions, 4'b0000);
    @(negedge clock);
    resetn = 1'b1;
    win("post_rst", 10, 64'd1 << 7, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
